// File: rtl/relay_station_skid_if.sv
// Stream handshake bundle around relay_station_skid: the slave side (valid_s/data_s/ready_s)
// and the master side (valid_m/data_m/ready_m). The slave modport is the relay's view.
interface relay_station_skid_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  ready_s;
  logic                  valid_s;
  logic [DATA_WIDTH-1:0] data_s;
  logic                  ready_m;
  logic                  valid_m;
  logic [DATA_WIDTH-1:0] data_m;

  modport slave (
    input  valid_s, data_s, ready_m,
    output ready_s, valid_m, data_m
  );

  modport master (
    output valid_s, data_s, ready_m,
    input  ready_s, valid_m, data_m
  );
endinterface

// File: rtl/relay_station_skid.sv
// Two-entry skid buffer: registered valid_m/data_m and ready_s, full throughput.
// Optional stall counter output enabled by defining RELAY_STATION_SKID_STATS_EN.
module relay_station_skid #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  relay_station_skid_if.slave   bus
`ifdef RELAY_STATION_SKID_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_t;

  state_t                state;
  state_t                state_next;
  logic                  valid_q;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] main_data;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  write;
  logic                  read;
  logic                  load_main;
  logic                  main_from_skid;
  logic                  load_skid;

  // A zero-width stall counter is meaningless; this keeps the parameter referenced in every build.
  if (CNT_WIDTH < 1) begin : g_cnt_width_invalid
  end

  assign write        = bus.valid_s & ready_q;
  assign read         = valid_q & bus.ready_m;
  assign bus.ready_s  = ready_q;
  assign bus.valid_m  = valid_q;
  assign bus.data_m   = main_data;

  always_comb begin
    state_next     = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (write) begin
          load_main  = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (write && read) begin
          load_main = 1'b1;
        end else if (write) begin
          load_skid  = 1'b1;
          state_next = FULL;
        end else if (read) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (read) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          state_next     = BUSY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Handshake outputs are flopped from the next state so neither has a combinational input path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state   <= state_next;
      valid_q <= (state_next == BUSY) || (state_next == FULL);
      ready_q <= (state_next != FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (load_main) begin
      main_data <= main_from_skid ? skid_data : bus.data_s;
    end
    if (load_skid) begin
      skid_data <= bus.data_s;
    end
  end

`ifdef RELAY_STATION_SKID_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (valid_q && !bus.ready_m && (stall_cnt != {CNT_WIDTH{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_relay_station_skid.sv
// Bench for relay_station_skid: directed vector table, reset/stats sequences, and random
// traffic checked against a two-deep queue model.
module tb_relay_station_skid;

  localparam int DW      = 8;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  relay_station_skid_if #(.DATA_WIDTH(DW)) bus ();

`ifdef RELAY_STATION_SKID_STATS_EN
  logic [CW-1:0] stall_cnt;

  relay_station_skid #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .stall_cnt (stall_cnt)
  );
`else
  relay_station_skid #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );
`endif

  typedef struct {
    logic          valid_s;
    logic [DW-1:0] data_s;
    logic          ready_m;
    logic          exp_valid_m;
    logic          exp_ready_s;
    logic [DW-1:0] exp_data_m;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] model_q[$];
  int            model_stall;
  int            n_compared   = 0;
  int            n_mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // The model is a FIFO of capacity two: a write lands when fewer than two words are held.
  task automatic applyStimulus(input logic vs, input logic [DW-1:0] d, input logic rm);
    bit wr;
    bit rd;
    bit stall;
    bus.valid_s = vs;
    bus.data_s  = d;
    bus.ready_m = rm;
    wr    = vs && (model_q.size() < 2);
    rd    = (model_q.size() > 0) && rm;
    stall = (model_q.size() > 0) && !rm;
    @(posedge clk);
    #1;
    if (rd) void'(model_q.pop_front());
    if (wr) model_q.push_back(d);
    if (stall && model_stall < CNT_MAX) model_stall++;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " valid_m"}, 32'(bus.valid_m), 32'(model_q.size() > 0));
    checkOutput({tag, " ready_s"}, 32'(bus.ready_s), 32'(model_q.size() < 2));
    if (model_q.size() > 0) checkOutput({tag, " data_m"}, 32'(bus.data_m), 32'(model_q[0]));
`ifdef RELAY_STATION_SKID_STATS_EN
    checkOutput({tag, " stall_cnt"}, 32'(stall_cnt), 32'(model_stall));
`endif
  endtask

  task automatic doReset(input int cycles);
    rst         = 1'b1;
    bus.valid_s = 1'b0;
    bus.data_s  = '0;
    bus.ready_m = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    model_q.delete();
    model_stall = 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 1; i <= 16; i++) vecs.push_back('{1'b1, DW'(i), 1'b1, 1'b1, 1'b1, DW'(i)});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00});
    // Backpressure: A2 fills the skid, A3 waits at the input until the first read.
    vecs.push_back('{1'b1, 8'hA1, 1'b1, 1'b1, 1'b1, 8'hA1});
    vecs.push_back('{1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 8'hA1});
    vecs.push_back('{1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 8'hA1});
    vecs.push_back('{1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 8'hA1});
    vecs.push_back('{1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA2});
    vecs.push_back('{1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA3});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00});
    vecs.push_back('{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 8'h55});
    vecs.push_back('{1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 8'h66});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00});

    doReset(2);
    checkOutput("reset valid_m", 32'(bus.valid_m), 32'd0);
    checkOutput("reset ready_s", 32'(bus.ready_s), 32'd1);
`ifdef RELAY_STATION_SKID_STATS_EN
    checkOutput("reset stall_cnt", 32'(stall_cnt), 32'd0);
`endif

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].valid_s, vecs[i].data_s, vecs[i].ready_m);
      checkOutput($sformatf("vec%0d valid_m", i), 32'(bus.valid_m), 32'(vecs[i].exp_valid_m));
      checkOutput($sformatf("vec%0d ready_s", i), 32'(bus.ready_s), 32'(vecs[i].exp_ready_s));
      if (vecs[i].exp_valid_m)
        checkOutput($sformatf("vec%0d data_m", i), 32'(bus.data_m), 32'(vecs[i].exp_data_m));
    end

    // Reset while FULL must discard both words.
    doReset(1);
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    checkOutput("full ready_s", 32'(bus.ready_s), 32'd0);
    checkOutput("full data_m", 32'(bus.data_m), 32'h11);
    doReset(1);
    checkOutput("midrst valid_m", 32'(bus.valid_m), 32'd0);
    checkOutput("midrst ready_s", 32'(bus.ready_s), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput($sformatf("postrst%0d valid_m", i), 32'(bus.valid_m), 32'd0);
    end

`ifdef RELAY_STATION_SKID_STATS_EN
    doReset(1);
    applyStimulus(1'b1, 8'h77, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("stats stall_cnt", 32'(stall_cnt), 32'(CNT_MAX));
    checkOutput("stats data_m", 32'(bus.data_m), 32'h77);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("stats saturated", 32'(stall_cnt), 32'(CNT_MAX));
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkModel("stats drain");
`endif

    doReset(1);
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom_range(0, 2) != 0));
      checkModel($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/relay_station_skid.md
Name: relay_station_skid

Overview:
- Two-entry valid/ready register slice (skid buffer) for the backward (ready) direction of the stream handshake.
- Registers both paths: valid_m/data_m forward, and ready_s backward, which is driven from a flop with no combinational path from ready_m.
- Sustains one transfer per cycle, unlike the single-entry relay station, which alternates empty/full.
- Inserted between stream producer and consumer to cut long ready paths in timing-critical pipelines.

Parameters:
- DATA_WIDTH, 8, payload width in bits.
- CNT_WIDTH, 16, width of the stall counter (used only with the optional feature).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, synchronous, active-high.
- ready_s  output  1  slave-side ready; registered; high when the skid entry is free.
- valid_s  input  1  slave-side valid.
- data_s  input  DATA_WIDTH  slave-side payload.
- ready_m  input  1  master-side ready from the consumer.
- valid_m  output  1  master-side valid; registered.
- data_m  output  DATA_WIDTH  master-side payload; registered main entry.
- stall_cnt  output  CNT_WIDTH  present only with RELAY_STATION_SKID_STATS_EN.

Behaviour:
- Definitions: write = valid_s & ready_s; read = valid_m & ready_m.
- Storage: main register (drives data_m) and skid register.
- States:
  - EMPTY: 0 entries.
  - BUSY: main valid.
  - FULL: main and skid valid.
- Outputs per state, all registered:
  - EMPTY: valid_m=0, ready_s=1.
  - BUSY: valid_m=1, ready_s=1.
  - FULL: valid_m=1, ready_s=0.
- Reset (rst=1 at a clk edge): state=EMPTY, valid_m=0, ready_s=1, stall_cnt=0. Data registers are not reset. Reset mid-operation discards both entries with no output transfer.
- Transitions:
  - EMPTY, write: main<=data_s, go to BUSY.
  - EMPTY, no write: stay.
  - BUSY, write & read: main<=data_s, stay BUSY (full throughput).
  - BUSY, write & !read: skid<=data_s, go to FULL; main unchanged.
  - BUSY, !write & read: go to EMPTY.
  - BUSY, neither: stay.
  - FULL, read: main<=skid, go to BUSY. valid_s is ignored because ready_s=0.
  - FULL, no read: stay; both entries held.
- Latency: a word accepted at edge N appears on data_m with valid_m=1 after edge N, i.e. 1 cycle.
- Ordering: strictly FIFO; no drop, no duplication.
- Stability: while valid_m=1 and ready_m=0, data_m and valid_m hold until read.
- Valid/ready rules:
  - ready_s is a function of registered state only.
  - valid_m does not depend combinationally on valid_s or ready_m.
  - data_s is sampled only on write.
- Unreachable state encodings recover to EMPTY.

Optional Feature:
- Macro: RELAY_STATION_SKID_STATS_EN.
- Defined:
  - Adds output stall_cnt.
  - Increments on every cycle with valid_m=1 and ready_m=0.
  - Saturates at 2^CNT_WIDTH-1 and does not wrap.
  - Cleared only by rst.
  - No effect on the datapath or handshake timing.
- Undefined: port stall_cnt and its logic are absent; the module has the base ports only.

Test Plan:
1. Reset: rst=1 for 2 cycles, then release with valid_s=0 -> valid_m=0, ready_s=1, stall_cnt=0, state EMPTY.
2. Streaming: ready_m=1 constant, valid_s=1 with data_s=0x01..0x10 on consecutive cycles -> data_m=0x01..0x10 each one cycle later, valid_m=1 for 16 consecutive cycles, ready_s stays 1.
3. Backpressure: stream 0xA1,0xA2,0xA3 with ready_m=0 from the cycle after 0xA1 is accepted:
   - ready_s falls to 0 after 0xA2 is accepted into the skid register.
   - 0xA3 is held at the input.
   - data_m holds 0xA1.
   - Raise ready_m -> output sequence 0xA1,0xA2,0xA3 in order with no gaps after release; ready_s returns to 1 one cycle after the first read.
4. Simultaneous read/write in BUSY: main=0x55, write 0x66 with ready_m=1 in the same cycle -> next cycle data_m=0x66, valid_m=1, state BUSY, skid unused.
5. Reset mid-operation: FULL holding 0x11/0x22, assert rst for 1 cycle -> valid_m=0, ready_s=1 next cycle; 0x11/0x22 never emitted after reset.
6. Stats (RELAY_STATION_SKID_STATS_EN, CNT_WIDTH=4): hold valid_m=1, ready_m=0 for 20 cycles -> stall_cnt reaches 15 and stays 15.
